fuzz_mem_model: RTL

Parametrised, cycle-accurate instruction/data memory model for the fuzzing harness. It replaces the fixed single-cycle, 32-bit model with one that has:
- valid/ready request channels and a configurable response latency;
- byte-enable writes;
- a bounded word store with per-word written flags;
- deterministic on-chip fill for never-touched locations: an external stimulus stream for imem, an internal LFSR for dmem.

It sits between the core's imem/dmem ports and the fuzzer's instruction stimulus source.

---
 rtl/fuzz_mem_model.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fuzz_mem_model.sv
// ---------------------------------------------------------------------------
// fuzz_mem_model
//
// Cycle-accurate instruction/data memory model for the fuzzing harness.
// Each port accepts one request per cycle on a valid/ready channel. Each port
// answers exactly LATENCY cycles after the accept.
//
// Words that have never been touched are filled deterministically on first
// access:
//   - imem: filled from the external stimulus stream (imem_fill_data, with
//     imem_fill_take pulsing in the consuming cycle).
//   - dmem: filled from an internal 32-bit Galois LFSR, replicated to DATA_W.
//
// Parameters:
//   DATA_W  - word width, 32 or 64
//   ADDR_W  - byte-address width
//   DEPTH   - words per memory, power of two
//   LATENCY - accept-to-response cycles, 1..4
//   SEED    - LFSR reset value, nonzero
//
// Ports:
//   clk, reset
//       Single clock; synchronous active-high reset.
//   imem_req_valid/ready/addr
//       Fetch request channel.
//   imem_resp_valid/data
//       Fetch response; no backpressure.
//   imem_fill_data, imem_fill_take
//       Stimulus word for unwritten fetch locations, and its consume strobe.
//   dmem_req_valid/ready/addr/data/wen/be
//       Data request channel (wen=1 is a write).
//   dmem_resp_valid/data
//       Data response. Reads return the read word; writes return the word as
//       stored after the byte merge.
//
// Build option:
//   UNIFIED_MEM_EN - when defined, imem and dmem share one array and one
//   written-flag set, so stores become visible to fetch (self-modifying code).
// ---------------------------------------------------------------------------
module fuzz_mem_model #(
  parameter int          DATA_W  = 32,
  parameter int          ADDR_W  = 32,
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 1,
  parameter logic [31:0] SEED    = 32'h0000_0001
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  imem_req_valid,
  output logic                  imem_req_ready,
  input  logic [ADDR_W-1:0]     imem_req_addr,
  output logic                  imem_resp_valid,
  output logic [DATA_W-1:0]     imem_resp_data,
  input  logic [DATA_W-1:0]     imem_fill_data,
  output logic                  imem_fill_take,
  input  logic                  dmem_req_valid,
  output logic                  dmem_req_ready,
  input  logic [ADDR_W-1:0]     dmem_req_addr,
  input  logic [DATA_W-1:0]     dmem_req_data,
  input  logic                  dmem_req_wen,
  input  logic [DATA_W/8-1:0]   dmem_req_be,
  output logic                  dmem_resp_valid,
  output logic [DATA_W-1:0]     dmem_resp_data
);

  localparam int          NB        = DATA_W / 8;
  localparam int          B         = $clog2(NB);
  localparam int          IW        = $clog2(DEPTH);
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  // Request accept and word indexing. Upper address bits alias modulo DEPTH.
  logic          imem_acc;
  logic          dmem_acc;
  logic [IW-1:0] imem_idx;
  logic [IW-1:0] dmem_idx;

  assign imem_req_ready = !reset;
  assign dmem_req_ready = !reset;
  assign imem_acc       = imem_req_valid && imem_req_ready;
  assign dmem_acc       = dmem_req_valid && dmem_req_ready;
  assign imem_idx       = imem_req_addr[IW+B-1:B];
  assign dmem_idx       = dmem_req_addr[IW+B-1:B];

  // Byte-offset and aliased high address bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{imem_req_addr[B-1:0], imem_req_addr[ADDR_W-1:IW+B],
                              dmem_req_addr[B-1:0], dmem_req_addr[ADDR_W-1:IW+B]};

  // Storage view seen by each port in the accept cycle.
  logic [DATA_W-1:0] imem_stored;
  logic [DATA_W-1:0] dmem_stored;
  logic              imem_hit;
  logic              dmem_hit;
  logic              same_fill;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_word;

`ifdef UNIFIED_MEM_EN
  logic [DATA_W-1:0] ram [DEPTH];
  logic [DEPTH-1:0]  flags_q;
  logic [DEPTH-1:0]  flags_d;

  assign imem_stored = ram[imem_idx];
  assign dmem_stored = ram[dmem_idx];
  assign imem_hit    = flags_q[imem_idx];
  assign dmem_hit    = flags_q[dmem_idx];

  // Both ports touching the same unwritten word: the stimulus word wins and
  // the dmem side sees it as its base instead of an LFSR value.
  assign same_fill = imem_fill_take && dmem_acc && (imem_idx == dmem_idx);

  always_comb begin
    flags_d = flags_q;
    if (imem_fill_take) flags_d[imem_idx] = 1'b1;
    if (dmem_we)        flags_d[dmem_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) flags_q <= '0;
    else       flags_q <= flags_d;
  end

  // dmem write is issued last so it merges over a same-cycle imem fill.
  always_ff @(posedge clk) begin
    if (imem_fill_take) ram[imem_idx] <= imem_fill_data;
    if (dmem_we)        ram[dmem_idx] <= dmem_word;
  end
`else
  logic [DATA_W-1:0] imem_ram [DEPTH];
  logic [DATA_W-1:0] dmem_ram [DEPTH];
  logic [DEPTH-1:0]  imem_flags_q;
  logic [DEPTH-1:0]  imem_flags_d;
  logic [DEPTH-1:0]  dmem_flags_q;
  logic [DEPTH-1:0]  dmem_flags_d;

  assign imem_stored = imem_ram[imem_idx];
  assign dmem_stored = dmem_ram[dmem_idx];
  assign imem_hit    = imem_flags_q[imem_idx];
  assign dmem_hit    = dmem_flags_q[dmem_idx];
  assign same_fill   = 1'b0;

  always_comb begin
    imem_flags_d = imem_flags_q;
    dmem_flags_d = dmem_flags_q;
    if (imem_fill_take) imem_flags_d[imem_idx] = 1'b1;
    if (dmem_we)        dmem_flags_d[dmem_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      imem_flags_q <= '0;
      dmem_flags_q <= '0;
    end else begin
      imem_flags_q <= imem_flags_d;
      dmem_flags_q <= dmem_flags_d;
    end
  end

  always_ff @(posedge clk) begin
    if (imem_fill_take) imem_ram[imem_idx] <= imem_fill_data;
    if (dmem_we)        dmem_ram[dmem_idx] <= dmem_word;
  end
`endif

  // imem: first touch consumes one stimulus word.
  logic [DATA_W-1:0] imem_word;
  assign imem_fill_take = imem_acc && !imem_hit;
  assign imem_word      = imem_fill_take ? imem_fill_data : imem_stored;

  // LFSR supplies fill for unwritten dmem words; it steps once per first touch.
  logic [31:0]       lfsr_q;
  logic [31:0]       lfsr_d;
  logic [DATA_W-1:0] lfsr_word;
  logic              lfsr_step;
  logic [DATA_W-1:0] dmem_base;

  assign lfsr_word = {(DATA_W/32){lfsr_q}};
  assign lfsr_step = dmem_acc && !dmem_hit && !same_fill;

  always_comb begin
    dmem_base = lfsr_word;
    if (dmem_hit)       dmem_base = dmem_stored;
    else if (same_fill) dmem_base = imem_fill_data;
    lfsr_d = lfsr_q;
    if (lfsr_step) lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 32'h0);
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  // Byte merge: enabled bytes take write data, others keep the base word.
  // For reads the result is simply the base (stored word or fresh fill).
  for (genvar gi = 0; gi < NB; gi++) begin : g_merge
    assign dmem_word[gi*8 +: 8] = (dmem_req_wen && dmem_req_be[gi]) ?
                                  dmem_req_data[gi*8 +: 8] : dmem_base[gi*8 +: 8];
  end

  // Writes always commit; reads commit only when they fill an unwritten word.
  assign dmem_we = dmem_acc && (dmem_req_wen || !dmem_hit);

  // Response pipelines: stage 0 captures the accept-cycle word, the last
  // stage drives the port. Data is zeroed when no request was accepted.
  logic [LATENCY-1:0] imem_vld_q;
  logic [LATENCY-1:0] imem_vld_d;
  logic [DATA_W-1:0]  imem_dat_q [LATENCY];
  logic [DATA_W-1:0]  imem_dat_d [LATENCY];
  logic [LATENCY-1:0] dmem_vld_q;
  logic [LATENCY-1:0] dmem_vld_d;
  logic [DATA_W-1:0]  dmem_dat_q [LATENCY];
  logic [DATA_W-1:0]  dmem_dat_d [LATENCY];

  assign imem_vld_d[0] = imem_acc;
  assign imem_dat_d[0] = imem_acc ? imem_word : '0;
  assign dmem_vld_d[0] = dmem_acc;
  assign dmem_dat_d[0] = dmem_acc ? dmem_word : '0;

  for (genvar gi = 1; gi < LATENCY; gi++) begin : g_pipe
    assign imem_vld_d[gi] = imem_vld_q[gi-1];
    assign imem_dat_d[gi] = imem_dat_q[gi-1];
    assign dmem_vld_d[gi] = dmem_vld_q[gi-1];
    assign dmem_dat_d[gi] = dmem_dat_q[gi-1];
  end

  // Reset flushes every in-flight response.
  always_ff @(posedge clk) begin
    if (reset) begin
      imem_vld_q <= '0;
      dmem_vld_q <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        imem_dat_q[k] <= '0;
        dmem_dat_q[k] <= '0;
      end
    end else begin
      imem_vld_q <= imem_vld_d;
      dmem_vld_q <= dmem_vld_d;
      imem_dat_q <= imem_dat_d;
      dmem_dat_q <= dmem_dat_d;
    end
  end

  assign imem_resp_valid = imem_vld_q[LATENCY-1];
  assign imem_resp_data  = imem_dat_q[LATENCY-1];
  assign dmem_resp_valid = dmem_vld_q[LATENCY-1];
  assign dmem_resp_data  = dmem_dat_q[LATENCY-1];

endmodule
